adc_pattern_gen: RTL and testbench
==================================

Name: adc_pattern_gen

Overview:
- Synthesisable, parametrised multi-channel ADC test-pattern source; next generation of the AD9643 behavioural model.
- Generalises the fixed 14-bit, 2-lane ramp/inverted-ramp output to N channels, selectable patterns, a programmable sample rate, pattern resync and per-channel over-range flags.
- Drives the DSP front-end in benches and in on-board loopback in place of the real converter; output is single-data-rate, one word per channel per sample.

Parameters:
- DATA_W, 14, sample width in bits (2..23).
- NUM_CH, 2, number of channels.
- DIV, 1, clocks per sample (>=1); sample strobe every DIV enabled clocks.
- CH_STEP, 0, per-channel offset: channel k adds k*CH_STEP (mod 2^DATA_W).
- CH_INV_MASK, 'b10, bit k set -> channel k output bit-inverted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  generator enable
- sync  in  1  single-cycle pattern realign pulse
- mode  in  3  pattern select (see Behaviour)
- fixed_word  in  DATA_W  constant for FIXED/TOGGLE modes
- dout  out  NUM_CH*DATA_W  channel k at [k*DATA_W +: DATA_W]
- dout_valid  out  1  one-cycle pulse per new sample
- or_flag  out  NUM_CH  over-range per channel, aligned with dout

Behaviour:
- Reset: dout=0, dout_valid=0, or_flag=0; divider=0; ramp=0; toggle phase=0; LFSR=seed 23'h7FFFFF.
- Divider counts 0..DIV-1 while en=1; strobe when count==DIV-1, then wraps to 0. DIV=1 -> strobe every enabled clock. en=0: divider holds, no strobe, dout/or_flag hold, dout_valid=0.
- On strobe in cycle t: base sample from current state registered to dout/or_flag at end of t; dout_valid=1 during t+1 only; generator state then advances. Latency strobe->dout = 1 clock.
- mode sampled on strobe only; state of all generators persists across mode changes (every generator advances on every strobe regardless of mode).
- Modes (base value): 0 OFF = 0; 1 RAMP_UP = ramp, ramp+1 mod 2^DATA_W; 2 RAMP_DN = ~ramp (counts down from all-ones); 3 FIXED = fixed_word; 4 TOGGLE = fixed_word when phase=0 else ~fixed_word, phase flips; 5 PN23 = LFSR[DATA_W-1:0], LFSR shifts left, new bit0 = s[22]^s[17]; 6,7 reserved -> OFF.
- Channel transform: ch_k = base + k*CH_STEP (mod 2^DATA_W), then ~ch_k if CH_INV_MASK[k].
- or_flag[k]=1 when transformed ch_k is all-zeros or all-ones (rail hit).
- sync=1: divider, ramp, phase, LFSR return to reset values; dout/or_flag hold; no strobe that cycle. First post-sync strobe DIV clocks later (if en), emits first pattern value (ramp 0).
- Simultaneous: rst > sync > strobe. sync during en=0 still realigns.
- Mid-operation rst: all outputs to reset values next edge; pulse in flight dropped.

Decomposition:
- Package adc_pat_pkg: mode enum (PAT_OFF..PAT_PN23), LFSR_W=23, LFSR_SEED, LFSR tap indices.
- Sub-module adc_pat_lfsr: 23-bit Fibonacci LFSR with step/load inputs; rest (divider, ramp, phase, channel mapping, OR) stays in top.

Test Plan:
- Defaults, mode=1, en=1 after rst: dout ch0=0,1,2..., ch1=16383,16382...; valid every clock; wrap 16383->0 with or_flag[0]=1 at 0 and 16383.
- DIV=4, mode=1: dout_valid every 4th clock; 3 samples = 0,1,2; en low 10 clocks -> no valid, dout holds 2; resume -> 3.
- mode=4, fixed_word=14'h1555: ch0 alternates 1555/2AAA, ch1 2AAA/1555; or_flag=0.
- mode=5: first 4 ch0 samples match golden PN23 model from seed 7FFFFF; sync mid-stream -> sequence restarts at seed value 3FFF.
- NUM_CH=4, CH_STEP=100, mode=1: first sample ch0..ch3 = 0,100,~200,300 per mask.
- sync and rst together, and sync on a strobe cycle: no valid that cycle, next sample ramp 0.

Source files
------------

// File: rtl/adc_pattern_gen_pkg.sv
// Shared definitions for the ADC test-pattern source: pattern modes and PN23 LFSR constants.
package adc_pat_pkg;

    typedef enum logic [2:0] {
        PAT_OFF     = 3'd0,
        PAT_RAMP_UP = 3'd1,
        PAT_RAMP_DN = 3'd2,
        PAT_FIXED   = 3'd3,
        PAT_TOGGLE  = 3'd4,
        PAT_PN23    = 3'd5
    } pat_mode_e;

    localparam int                LFSR_W     = 23;
    localparam logic [LFSR_W-1:0] LFSR_SEED  = 23'h7FFFFF;
    localparam int                LFSR_TAP_A = 22;
    localparam int                LFSR_TAP_B = 17;

endpackage

// File: rtl/adc_pattern_gen_if.sv
// Control and sample bus of the pattern source; master is the generator, slave the consumer.
interface adc_pattern_gen_if #(
    parameter int DATA_W = 14,
    parameter int NUM_CH = 2
);
    logic                     en;
    logic                     sync;
    logic [2:0]               mode;
    logic [DATA_W-1:0]        fixed_word;
    logic [NUM_CH*DATA_W-1:0] dout;
    logic                     dout_valid;
    logic [NUM_CH-1:0]        or_flag;

    modport master (
        input  en, sync, mode, fixed_word,
        output dout, dout_valid, or_flag
    );

    modport slave (
        output en, sync, mode, fixed_word,
        input  dout, dout_valid, or_flag
    );
endinterface

// File: rtl/adc_pat_lfsr.sv
// 23-bit Fibonacci LFSR (x^23 + x^18 + 1); shifts left on step, reloads the seed on load.
module adc_pat_lfsr
    import adc_pat_pkg::*;
#(
    parameter int OUT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    output logic [OUT_W-1:0] state_o
);
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // Next state: realign beats advance, so a load in the same cycle wins.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i)
            lfsr_d = LFSR_SEED;
        else if (step_i)
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
    end

    // State register, seeded on reset.
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign state_o = lfsr_q[OUT_W-1:0];
endmodule

// File: rtl/adc_pattern_gen.sv
// Multi-channel ADC test-pattern source: sample-rate divider, pattern generators,
// per-channel offset/inversion and rail-hit over-range flags.
module adc_pattern_gen
    import adc_pat_pkg::*;
#(
    parameter int                DATA_W      = 14,
    parameter int                NUM_CH      = 2,
    parameter int                DIV         = 1,
    parameter int                CH_STEP     = 0,
    parameter logic [NUM_CH-1:0] CH_INV_MASK = NUM_CH'(2)
) (
    input  logic              clk,
    input  logic              rst,
    adc_pattern_gen_if.master bus
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]        ramp_q, ramp_d;
    logic                     phase_q, phase_d;
    logic                     strobe;
    logic [DATA_W-1:0]        base;
    logic [DATA_W-1:0]        pn_word;
    logic [NUM_CH*DATA_W-1:0] ch_d;
    logic [NUM_CH-1:0]        or_d;
    logic [NUM_CH*DATA_W-1:0] dout_q;
    logic [NUM_CH-1:0]        or_q;
    logic                     vld_q;

    // Divider and generator next state; sync realigns and suppresses the strobe.
    always_comb begin
        strobe  = bus.en && !bus.sync && (cnt_q == CNT_W'(DIV - 1));
        cnt_d   = cnt_q;
        ramp_d  = ramp_q;
        phase_d = phase_q;
        if (bus.sync) begin
            cnt_d   = '0;
            ramp_d  = '0;
            phase_d = 1'b0;
        end else if (strobe) begin
            cnt_d   = '0;
            ramp_d  = ramp_q + DATA_W'(1);
            phase_d = ~phase_q;
        end else if (bus.en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    adc_pat_lfsr #(.OUT_W(DATA_W)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (bus.sync),
        .step_i (strobe),
        .state_o(pn_word)
    );

    // Base sample from the current generator state; reserved modes read as OFF.
    always_comb begin
        base = '0;
        case (bus.mode)
            PAT_RAMP_UP: base = ramp_q;
            PAT_RAMP_DN: base = ~ramp_q;
            PAT_FIXED:   base = bus.fixed_word;
            PAT_TOGGLE:  base = phase_q ? ~bus.fixed_word : bus.fixed_word;
            PAT_PN23:    base = pn_word;
            default:     base = '0;
        endcase
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] ch;
        assign ch = (base + DATA_W'(k * CH_STEP)) ^ {DATA_W{CH_INV_MASK[k]}};
        assign ch_d[k*DATA_W +: DATA_W] = ch;
        assign or_d[k] = (ch == '0) || (ch == '1);
    end

    // State and output registers; outputs only move on a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            ramp_q  <= '0;
            phase_q <= 1'b0;
            dout_q  <= '0;
            or_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ramp_q  <= ramp_d;
            phase_q <= phase_d;
            vld_q   <= strobe;
            if (strobe) begin
                dout_q <= ch_d;
                or_q   <= or_d;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.or_flag    = or_q;
    assign bus.dout_valid = vld_q;
endmodule

// File: tb/tb_adc_pattern_gen.sv
// Scoreboard bench for two generator configurations driven by shared random stimulus.
module tb_adc_pattern_gen;
    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic        sync = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [13:0] fw   = 14'd0;

    always #5 clk = ~clk;

    adc_pattern_gen_if #(.DATA_W(14), .NUM_CH(2)) ifa ();
    adc_pattern_gen_if #(.DATA_W(14), .NUM_CH(4)) ifb ();

    assign ifa.en = en;   assign ifa.sync = sync; assign ifa.mode = mode; assign ifa.fixed_word = fw;
    assign ifb.en = en;   assign ifb.sync = sync; assign ifb.mode = mode; assign ifb.fixed_word = fw;

    adc_pattern_gen #(.DATA_W(14), .NUM_CH(2), .DIV(1), .CH_STEP(0), .CH_INV_MASK(2'b10))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    adc_pattern_gen #(.DATA_W(14), .NUM_CH(4), .DIV(4), .CH_STEP(100), .CH_INV_MASK(4'b0100))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int          errors = 0;
    int          checks = 0;
    logic [67:0] q    [2][$];
    logic [67:0] hold [2];

    int          m_div  [2] = '{1, 4};
    int          m_nch  [2] = '{2, 4};
    int          m_step [2] = '{0, 100};
    logic [3:0]  m_mask [2] = '{4'b0010, 4'b0100};

    // Reference state: enabled clocks since realign, samples emitted since realign, PN23 register.
    int          m_cnt [2];
    int          m_n   [2];
    logic [22:0] m_lf  [2];

    function automatic logic [67:0] expect_word(int id, logic [2:0] md, logic [13:0] f,
                                                int nn, logic [22:0] l);
        logic [13:0] base, c;
        logic [63:0] d;
        logic [3:0]  o;
        logic [31:0] nv;
        nv = nn;
        d = '0; o = '0;
        case (md)
            3'd1:    base = nv[13:0];
            3'd2:    base = 14'h3FFF - nv[13:0];
            3'd3:    base = f;
            3'd4:    base = nv[0] ? ~f : f;
            3'd5:    base = l[13:0];
            default: base = 14'd0;
        endcase
        for (int k = 0; k < m_nch[id]; k++) begin
            c = 14'((32'(base) + k * m_step[id]) % 16384);
            if (m_mask[id][k]) c = 14'h3FFF - c;
            d[k*14 +: 14] = c;
            o[k] = (c == 14'd0) || (c == 14'h3FFF);
        end
        return {o, d};
    endfunction

    // Reference model: decides from the spec rules which clocks emit a sample.
    initial forever begin
        @(posedge clk);
        for (int id = 0; id < 2; id++) begin
            if (rst) begin
                m_cnt[id] = 0; m_n[id] = 0; m_lf[id] = 23'h7FFFFF;
                q[id].delete();
            end else if (sync) begin
                m_cnt[id] = 0; m_n[id] = 0; m_lf[id] = 23'h7FFFFF;
            end else if (en) begin
                if (m_cnt[id] == m_div[id] - 1) begin
                    q[id].push_back(expect_word(id, mode, fw, m_n[id], m_lf[id]));
                    m_n[id]++;
                    m_lf[id] = {m_lf[id][21:0], m_lf[id][22] ^ m_lf[id][17]};
                    m_cnt[id] = 0;
                end else begin
                    m_cnt[id]++;
                end
            end
        end
    end

    // Monitor: pops on every valid, otherwise checks that outputs hold.
    initial forever begin
        logic        v;
        logic [67:0] got, exp;
        @(posedge clk);
        #1;
        for (int id = 0; id < 2; id++) begin
            if (id == 0) begin v = ifa.dout_valid; got = {4'(ifa.or_flag), 64'(ifa.dout)}; end
            else         begin v = ifb.dout_valid; got = {4'(ifb.or_flag), 64'(ifb.dout)}; end
            checks++;
            if (rst) begin
                hold[id] = '0;
                if (v !== 1'b0 || got !== 68'd0) begin
                    errors++;
                    $display("FAIL reset dut%0d: got valid=%b %h want valid=0 0", id, v, got);
                end
            end else if (v === 1'b1) begin
                if (q[id].size() == 0) begin
                    errors++;
                    $display("FAIL spurious_valid dut%0d: got valid=1 %h want no sample", id, got);
                end else begin
                    exp = q[id].pop_front();
                    hold[id] = exp;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL sample dut%0d: got %h want %h", id, got, exp);
                    end
                end
            end else begin
                if (q[id].size() != 0) begin
                    errors++;
                    $display("FAIL missing_valid dut%0d: got valid=%b want 1 for %h", id, v, q[id][0]);
                    void'(q[id].pop_front());
                end else if (got !== hold[id]) begin
                    errors++;
                    $display("FAIL hold dut%0d: got %h want %h", id, got, hold[id]);
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(3);
        rst = 1'b0; mode = 3'd1; en = 1'b1;
        cyc(16400);                                  // full ramp wrap on the DIV=1 instance
        en = 1'b0; cyc(10); en = 1'b1; cyc(20);      // pause and resume
        mode = 3'd4; fw = 14'h1555; cyc(30);         // toggle
        mode = 3'd5; cyc(40);                        // PN23 from seed
        sync = 1'b1; cyc(1); sync = 1'b0; cyc(40);   // realign mid-stream
        sync = 1'b1; rst = 1'b1; cyc(1);             // reset wins over sync
        sync = 1'b0; rst = 1'b0; mode = 3'd1; cyc(12);
        en = 1'b0; sync = 1'b1; cyc(1);              // realign while disabled
        sync = 1'b0; cyc(3); en = 1'b1; cyc(12);
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom % 100) == 0;
            sync = ($urandom % 30) == 0;
            en   = ($urandom % 5) != 0;
            mode = 3'($urandom % 8);
            if (($urandom % 16) == 0) fw = 14'($urandom);
            cyc(1);
        end
        rst = 1'b0; sync = 1'b0; en = 1'b0;
        cyc(3);
        checks++;
        if (q[0].size() + q[1].size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q[0].size() + q[1].size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
